// File: rtl/regfile_pkg.sv
// Shared widths, requester IDs and the write-back payload used by the
// register-file write arbiter.
package regfile_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

   typedef enum logic {
      REQ_ALU  = 1'b0,
      REQ_LOAD = 1'b1
   } req_id_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // Register 0 is hard-wired; nothing ever writes or reserves it.
   function automatic logic is_real_reg(input logic [ADDR_W-1:0] addr);
      return addr != REG_ZERO;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   output logic [1:0] grant
);

   req_id_e rr_last;

   // Grant is combinational; nothing is granted while reset is held.
   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_last == REQ_LOAD) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last <= REQ_LOAD;
      end else if (grant[0]) begin
         rr_last <= REQ_ALU;
      end else if (grant[1]) begin
         rr_last <= REQ_LOAD;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU and load write-back and
// tracks per-register busy bits for RAW hazard detection.
module regfile_write_arbiter
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic              hazard,
   output logic              Write,
   output logic [ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0] WriteData
);

   logic [1:0]          grant;
   logic                accept;
   wb_req_t             sel;
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .valid ({req1_valid, req0_valid}),
      .grant (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept     = |grant;

   always_comb begin
      sel = '{addr: req0_addr, data: req0_data};
      if (grant[1]) begin
         sel = '{addr: req1_addr, data: req1_data};
      end
   end

   // While reset is held the scoreboard is being cleared, so any reservation may proceed.
   assign rsv_ready = rsv_valid & (reset | ~is_real_reg(rsv_addr) | ~busy[rsv_addr]);
   assign hazard    = busy[rs_addr] | busy[rt_addr];

   // Clear for the issuing write first, then set for a new reservation so it wins.
   always_comb begin
      busy_nxt = busy;
      if (accept && is_real_reg(sel.addr)) begin
         busy_nxt[sel.addr] = 1'b0;
      end
      if (rsv_ready && is_real_reg(rsv_addr)) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
      busy_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Write port registers; index/data hold when nothing is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         Write         <= 1'b0;
         WriteRegister <= REG_ZERO;
         WriteData     <= DATA_W'(0);
      end else begin
         Write <= accept & is_real_reg(sel.addr);
         if (accept) begin
            WriteRegister <= sel.addr;
            WriteData     <= sel.data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a negedge-commit register file model.
module tb_regfile_write_arbiter;
   import regfile_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0_valid, req1_valid, rsv_valid;
   logic [ADDR_W-1:0] req0_addr, req1_addr, rsv_addr, rs_addr, rt_addr;
   logic [DATA_W-1:0] req0_data, req1_data;
   logic              req0_ready, req1_ready, rsv_ready, hazard;
   logic              Write;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;

   logic [DATA_W-1:0] rf [NUM_REGS];

   int n_checks = 0;
   int n_fail   = 0;

   regfile_write_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .req0_valid    (req0_valid),
      .req0_addr     (req0_addr),
      .req0_data     (req0_data),
      .req0_ready    (req0_ready),
      .req1_valid    (req1_valid),
      .req1_addr     (req1_addr),
      .req1_data     (req1_data),
      .req1_ready    (req1_ready),
      .rsv_valid     (rsv_valid),
      .rsv_addr      (rsv_addr),
      .rsv_ready     (rsv_ready),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .hazard        (hazard),
      .Write         (Write),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData)
   );

   always #5 clk = ~clk;

   // Register file model: commits on the negedge inside the issue cycle.
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= '0;
      end else if (Write) begin
         rf[WriteRegister] <= WriteData;
      end
   end

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DATA_W-1:0] d0, d1, exp_d;
      logic [ADDR_W-1:0] exp_a;
      logic              g1;

      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1111_1111;
      req1_valid = 1'b0; req1_addr = '0;   req1_data = '0;
      rsv_valid  = 1'b1; rsv_addr  = 5'd7;
      rs_addr    = 5'd7; rt_addr   = 5'd3;

      // T1: reset held two cycles with a pending request
      step();
      step();
      check("t1_write", DATA_W'(Write), 32'd0);
      check("t1_req0_ready", DATA_W'(req0_ready), 32'd0);
      check("t1_hazard", DATA_W'(hazard), 32'd0);
      check("t1_rsv_ready_7", DATA_W'(rsv_ready), 32'd1);
      rsv_addr = 5'd20;
      #1;
      check("t1_rsv_ready_20", DATA_W'(rsv_ready), 32'd1);
      step();
      check("t1_write_after", DATA_W'(Write), 32'd0);
      check("t1_wr_after", DATA_W'(WriteRegister), 32'd0);

      reset = 1'b0; req0_valid = 1'b0; rsv_valid = 1'b0;
      rs_addr = 5'd0; rt_addr = 5'd0;

      // T2: single ALU write
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
      #1;
      check("t2_req0_ready", DATA_W'(req0_ready), 32'd1);
      check("t2_req1_ready", DATA_W'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      check("t2_write", DATA_W'(Write), 32'd1);
      check("t2_wr", DATA_W'(WriteRegister), 32'd5);
      check("t2_wd", WriteData, 32'hDEAD_BEEF);
      step();
      check("t2_write_idle", DATA_W'(Write), 32'd0);
      check("t2_wr_hold", DATA_W'(WriteRegister), 32'd5);
      check("t2_wd_hold", WriteData, 32'hDEAD_BEEF);
      check("t2_rf5", rf[5], 32'hDEAD_BEEF);

      // T4: load write to register 0 is accepted but never issued
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
      #1;
      check("t4_req1_ready", DATA_W'(req1_ready), 32'd1);
      step();
      req1_valid = 1'b0;
      check("t4_write", DATA_W'(Write), 32'd0);
      step();
      check("t4_rf0", rf[0], 32'd0);

      // T3: contention, last grant was req1 so req0 goes first
      d0 = 32'hA000_0000; d1 = 32'hB000_0000;
      req0_valid = 1'b1; req0_addr = 5'd1;
      req1_valid = 1'b1; req1_addr = 5'd2;
      for (int i = 0; i < 4; i++) begin
         req0_data = d0; req1_data = d1;
         g1 = (i % 2) == 1;
         #1;
         check($sformatf("t3_req0_ready_%0d", i), DATA_W'(req0_ready), DATA_W'(!g1));
         check($sformatf("t3_req1_ready_%0d", i), DATA_W'(req1_ready), DATA_W'(g1));
         exp_a = g1 ? 5'd2 : 5'd1;
         exp_d = g1 ? d1 : d0;
         step();
         check($sformatf("t3_write_%0d", i), DATA_W'(Write), 32'd1);
         check($sformatf("t3_wr_%0d", i), DATA_W'(WriteRegister), DATA_W'(exp_a));
         check($sformatf("t3_wd_%0d", i), WriteData, exp_d);
         if (g1) d1 = d1 + 32'd1;
         else    d0 = d0 + 32'd1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      check("t3_rf1", rf[1], 32'hA000_0001);
      check("t3_rf2", rf[2], 32'hB000_0001);

      // T5: scoreboard reserve / hazard / clear
      rsv_valid = 1'b1; rsv_addr = 5'd7;
      #1;
      check("t5_rsv_ready_first", DATA_W'(rsv_ready), 32'd1);
      step();
      rs_addr = 5'd7;
      #1;
      check("t5_rsv_ready_busy", DATA_W'(rsv_ready), 32'd0);
      check("t5_hazard_rs", DATA_W'(hazard), 32'd1);
      rsv_valid = 1'b0;
      rs_addr = 5'd0; rt_addr = 5'd7;
      #1;
      check("t5_hazard_rt", DATA_W'(hazard), 32'd1);
      rt_addr = 5'd0;
      #1;
      check("t5_hazard_zero", DATA_W'(hazard), 32'd0);
      rs_addr = 5'd7;
      req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
      #1;
      check("t5_req0_ready", DATA_W'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      check("t5_hazard_cleared", DATA_W'(hazard), 32'd0);
      check("t5_wr", DATA_W'(WriteRegister), 32'd7);

      // T6: reservation and write of the same register in one cycle
      rsv_valid = 1'b1; rsv_addr = 5'd9;
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0099;
      #1;
      check("t6_rsv_ready", DATA_W'(rsv_ready), 32'd1);
      check("t6_req0_ready", DATA_W'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      rs_addr = 5'd9;
      #1;
      check("t6_hazard", DATA_W'(hazard), 32'd1);
      check("t6_rsv_ready_busy", DATA_W'(rsv_ready), 32'd0);
      check("t6_write", DATA_W'(Write), 32'd1);
      check("t6_wr", DATA_W'(WriteRegister), 32'd9);
      rsv_valid = 1'b0;

      // Reset coincident with a pending request drops it and clears busy
      req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h0000_0444;
      reset = 1'b1;
      #1;
      check("rst_req0_ready", DATA_W'(req0_ready), 32'd0);
      step();
      reset = 1'b0; req0_valid = 1'b0;
      #1;
      check("rst_write", DATA_W'(Write), 32'd0);
      check("rst_hazard", DATA_W'(hazard), 32'd0);
      step();
      check("rst_rf4", rf[4], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
